// File: rtl/sop_equiv_sweeper_pkg.sv
// Shared definitions for the SOP equivalence sweeper.
// Holds the FSM state encoding and the helper that sizes the vector space.
package sop_equiv_sweeper_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSweep = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned DefNIn = 4;
  localparam int unsigned N_VEC  = 32'd1 << DefNIn;

  // Number of input vectors of an n_in-input function (2**n_in).
  function automatic int unsigned n_vec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/sop_equiv_sweeper_sop_eval.sv
// Combinational sum-of-products evaluator.
// Ports:
//   vec  - input vector under evaluation (bit N_IN-1 is input A)
//   care - per-term care masks, term t at [t*N_IN +: N_IN]
//   val  - per-term required literal values, same slicing
//   en   - per-term enables
//   sop  - OR of all enabled, satisfied product terms
module sop_eval #(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned N_TERMS = 4
) (
  input  logic [N_IN-1:0]         vec,
  input  logic [N_TERMS*N_IN-1:0] care,
  input  logic [N_TERMS*N_IN-1:0] val,
  input  logic [N_TERMS-1:0]      en,
  output logic                    sop
);

  logic [N_TERMS-1:0] term_hit;

  for (genvar t = 0; t < N_TERMS; t++) begin : g_term
    // A term with an all-zero care mask matches every vector (constant 1).
    assign term_hit[t] = en[t] &&
                         (((vec ^ val[t*N_IN +: N_IN]) & care[t*N_IN +: N_IN]) == '0);
  end

  assign sop = |term_hit;

endmodule

// File: rtl/sop_equiv_sweeper.sv
// Sequential exhaustive equivalence checker for a programmable SOP against a
// reference truth table. A start pulse in idle snapshots the configuration,
// then every vector 0..2**N_IN-1 is evaluated one per clock.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - begin a sweep (honoured only when idle)
//   ref_tt          - reference truth table, bit v = F(v)
//   term_care/val   - per-term care mask / literal values, term t at [t*N_IN +: N_IN]
//   term_en         - per-term enable
//   busy, done      - sweep in progress / one-cycle completion pulse
//   equal           - last completed sweep had zero mismatches
//   mismatch_cnt    - mismatching vector count of the last sweep
//   first_bad       - lowest mismatching vector (0 if none)
//   cur_vec         - vector currently under evaluation
module sop_equiv_sweeper
  import sop_equiv_sweeper_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned N_TERMS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [(1<<N_IN)-1:0]      ref_tt,
  input  logic [N_TERMS*N_IN-1:0]   term_care,
  input  logic [N_TERMS*N_IN-1:0]   term_val,
  input  logic [N_TERMS-1:0]        term_en,
  output logic                      busy,
  output logic                      done,
  output logic                      equal,
  output logic [N_IN:0]             mismatch_cnt,
  output logic [N_IN-1:0]           first_bad,
  output logic [N_IN-1:0]           cur_vec
);

  localparam int unsigned NVec  = n_vec(N_IN);
  localparam int unsigned CntW  = N_IN + 1;
  localparam int unsigned TermW = N_TERMS * N_IN;

  state_e               state_q, state_d;
  logic [N_IN-1:0]      cur_vec_q, cur_vec_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [N_IN-1:0]      first_bad_q, first_bad_d;
  logic                 equal_q, equal_d;

  // Shadow configuration so inputs may change freely during a sweep.
  logic [NVec-1:0]      ref_tt_q, ref_tt_d;
  logic [TermW-1:0]     care_q, care_d;
  logic [TermW-1:0]     val_q, val_d;
  logic [N_TERMS-1:0]   en_q, en_d;

  logic                 sop;
  logic                 mismatch;

  sop_eval #(
    .N_IN    (N_IN),
    .N_TERMS (N_TERMS)
  ) u_sop_eval (
    .vec  (cur_vec_q),
    .care (care_q),
    .val  (val_q),
    .en   (en_q),
    .sop  (sop)
  );

  assign mismatch = sop ^ ref_tt_q[cur_vec_q];

  always_comb begin
    state_d     = state_q;
    cur_vec_d   = cur_vec_q;
    cnt_d       = cnt_q;
    first_bad_d = first_bad_q;
    equal_d     = equal_q;
    ref_tt_d    = ref_tt_q;
    care_d      = care_q;
    val_d       = val_q;
    en_d        = en_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ref_tt_d    = ref_tt;
          care_d      = term_care;
          val_d       = term_val;
          en_d        = term_en;
          cnt_d       = '0;
          first_bad_d = '0;
          equal_d     = 1'b0;
          cur_vec_d   = '0;
          state_d     = StSweep;
        end
      end
      StSweep: begin
        if (mismatch) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == '0) first_bad_d = cur_vec_q;
        end
        // Natural wrap returns cur_vec to 0 after the last vector.
        cur_vec_d = cur_vec_q + N_IN'(1);
        if (&cur_vec_q) begin
          equal_d = (cnt_d == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_vec_q   <= '0;
      cnt_q       <= '0;
      first_bad_q <= '0;
      equal_q     <= 1'b0;
      ref_tt_q    <= '0;
      care_q      <= '0;
      val_q       <= '0;
      en_q        <= '0;
    end else begin
      state_q     <= state_d;
      cur_vec_q   <= cur_vec_d;
      cnt_q       <= cnt_d;
      first_bad_q <= first_bad_d;
      equal_q     <= equal_d;
      ref_tt_q    <= ref_tt_d;
      care_q      <= care_d;
      val_q       <= val_d;
      en_q        <= en_d;
    end
  end

  assign busy         = (state_q == StSweep);
  assign done         = (state_q == StDone);
  assign equal        = equal_q;
  assign mismatch_cnt = cnt_q;
  assign first_bad    = first_bad_q;
  assign cur_vec      = cur_vec_q;

endmodule

// File: tb/tb_sop_equiv_sweeper.sv
// Self-checking bench for sop_equiv_sweeper (N_IN=4, N_TERMS=4).
// Expected results are queued when a sweep is started and compared at done.
module tb_sop_equiv_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] ref_tt;
  logic [15:0] term_care;
  logic [15:0] term_val;
  logic [3:0]  term_en;
  logic        busy;
  logic        done;
  logic        equal;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_bad;
  logic [3:0]  cur_vec;

  typedef struct packed {
    logic       eq;
    logic [4:0] cnt;
    logic [3:0] fb;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Terms, slot t at [t*4 +: 4]: t0=BD, t1=CD, t2=A'C'D', t3=BCD'
  localparam logic [15:0] Care4 = {4'b0111, 4'b1011, 4'b0011, 4'b0101};
  localparam logic [15:0] Val4  = {4'b0110, 4'b0000, 4'b0011, 4'b0101};

  sop_equiv_sweeper #(
    .N_IN    (4),
    .N_TERMS (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ref_tt       (ref_tt),
    .term_care    (term_care),
    .term_val     (term_val),
    .term_en      (term_en),
    .busy         (busy),
    .done         (done),
    .equal        (equal),
    .mismatch_cnt (mismatch_cnt),
    .first_bad    (first_bad),
    .cur_vec      (cur_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_start(input logic [15:0] tt, input logic [15:0] care,
                             input logic [15:0] val, input logic [3:0] en, input exp_t e);
    @(negedge clk);
    ref_tt    = tt;
    term_care = care;
    term_val  = val;
    term_en   = en;
    start     = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("cur_vec_after_start", cur_vec, 0);
  endtask

  // Waits for done, counting evaluation edges; optionally re-pulses start at a
  // given vector and scrambles the live config to prove the shadow copy is used.
  task automatic wait_done(input string tag, input int repulse_at, input bit scramble);
    int   n    = 0;
    bit   seen = 1'b0;
    exp_t e;
    logic       eq_s;
    logic [4:0] cnt_s;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy && int'(cur_vec) == repulse_at) begin
          start   = 1'b1;
          ref_tt  = ~ref_tt;
          term_en = 4'b0000;
        end
        if (scramble) begin
          ref_tt    = 16'($urandom);
          term_care = 16'($urandom);
          term_val  = 16'($urandom);
          term_en   = 4'($urandom);
        end
      end
    end
    check_eq({tag, "_done_seen"}, seen, 1);
    if (!seen) begin
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    check_eq({tag, "_latency"}, n, 16);
    check_eq({tag, "_busy_in_done"}, busy, 0);
    check_eq({tag, "_cur_vec_wrap"}, cur_vec, 0);
    check_eq({tag, "_sb_nonempty"}, sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({tag, "_equal"}, equal, e.eq);
      check_eq({tag, "_mismatch_cnt"}, mismatch_cnt, e.cnt);
      check_eq({tag, "_first_bad"}, first_bad, e.fb);
    end
    // Start during the done cycle must be ignored; results must persist.
    eq_s  = equal;
    cnt_s = mismatch_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "_start_in_done_ignored"}, busy, 0);
    check_eq({tag, "_done_one_cycle"}, done, 0);
    check_eq({tag, "_equal_persists"}, equal, eq_s);
    check_eq({tag, "_cnt_persists"}, mismatch_cnt, cnt_s);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    ref_tt    = '0;
    term_care = '0;
    term_val  = '0;
    term_en   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_equal", equal, 0);
    check_eq("reset_cnt", mismatch_cnt, 0);
    check_eq("reset_first_bad", first_bad, 0);
    check_eq("reset_cur_vec", cur_vec, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // BD + CD + A'C'D' against its own truth table.
    drive_start(16'hA8B9, Care4, Val4, 4'b0111, '{eq: 1'b1, cnt: 5'd0, fb: 4'd0});
    wait_done("three_terms_eq", -1, 1'b0);

    // Reference also contains BCD': vectors 6 and 14 differ.
    drive_start(16'hE8F9, Care4, Val4, 4'b0111, '{eq: 1'b0, cnt: 5'd2, fb: 4'd6});
    wait_done("missing_bcd", -1, 1'b1);

    drive_start(16'hE8F9, Care4, Val4, 4'b1111, '{eq: 1'b1, cnt: 5'd0, fb: 4'd0});
    wait_done("four_terms_eq", -1, 1'b0);

    // All terms disabled -> sop=0 everywhere.
    drive_start(16'hFFFF, Care4, Val4, 4'b0000, '{eq: 1'b0, cnt: 5'd16, fb: 4'd0});
    wait_done("all_disabled", -1, 1'b0);

    // Single term with empty care mask is constant 1.
    drive_start(16'hFFFF, 16'h0000, 16'h0000, 4'b0001, '{eq: 1'b1, cnt: 5'd0, fb: 4'd0});
    wait_done("care_zero", -1, 1'b0);

    // Start re-pulsed mid-sweep is ignored.
    drive_start(16'hA8B9, Care4, Val4, 4'b0111, '{eq: 1'b1, cnt: 5'd0, fb: 4'd0});
    wait_done("repulse", 3, 1'b0);

    // Reset mid-sweep at vector 7: outputs clear, no done, result discarded.
    drive_start(16'hFFFF, Care4, Val4, 4'b0000, '{eq: 1'b0, cnt: 5'd16, fb: 4'd0});
    n = 0;
    while (cur_vec != 4'd7 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("abort_reached_vec7", cur_vec, 7);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_equal", equal, 0);
    check_eq("abort_cnt", mismatch_cnt, 0);
    check_eq("abort_first_bad", first_bad, 0);
    check_eq("abort_cur_vec", cur_vec, 0);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("abort_no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check_eq("post_abort_no_done", done, 0);
    end

    // Full sweep after the abort.
    drive_start(16'hE8F9, Care4, Val4, 4'b0111, '{eq: 1'b0, cnt: 5'd2, fb: 4'd6});
    wait_done("after_abort", -1, 1'b0);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
